// File: rtl/can_crc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : can_crc_sequencer
// Purpose  : Sequences one standard-format CAN frame through the shared
//            CRC_Unit. On an accepted start it latches the frame descriptor,
//            clears the CRC unit and serialises the CRC scope as
//            SOF, ID[10:0], RTR, IDE, r0, DLC[3:0], data. It then captures
//            the 15-bit CRC for the transmit and receive framers.
//            Each scope bit takes two cycles: value first, then strobe.
// Ports    : clock, reset_n      - rising-edge clock, synchronous active-low reset
//            start               - request (accepted only when idle)
//            id_in/rtr_in/dlc_in/data_in - frame descriptor (data byte 0 in [63:56])
//            busy, done          - sequence in progress / one-cycle result pulse
//            crc_valid, crc_out  - captured CRC and its valid flag
//            crc_bitval/bitstrb/clear, crc_in - CRC_Unit interface
//            crc_mismatch        - internal self-check disagreement
// Options  : CAN_CRC_SELFCHECK_EN - builds a shadow CRC-15 LFSR that is
//            compared with crc_in at capture; otherwise crc_mismatch is 0.
// Revision : 1.0 - initial release
// ============================================================================
module can_crc_sequencer #(
    parameter int MAX_DLC = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [10:0] id_in,
    input  logic        rtr_in,
    input  logic [3:0]  dlc_in,
    input  logic [63:0] data_in,
    output logic        busy,
    output logic        done,
    output logic        crc_valid,
    output logic [14:0] crc_out,
    output logic        crc_bitval,
    output logic        crc_bitstrb,
    output logic        crc_clear,
    input  logic [14:0] crc_in,
    output logic        crc_mismatch
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CLEAR   = 2'd1;
    localparam logic [1:0] S_SHIFT   = 2'd2;
    localparam logic [1:0] S_CAPTURE = 2'd3;

    localparam logic [3:0] c_MAX_DLC = 4'(MAX_DLC);

    // State and datapath registers
    logic [1:0]  r_state;
    logic        r_phase;
    logic [6:0]  r_index;
    logic [6:0]  r_nbits;
    logic [82:0] r_scope;   // scope bits, next bit to send always at [82]
    logic        r_busy;
    logic        r_done;
    logic        r_valid;
    logic [14:0] r_crc;
    logic        r_bitval;
    logic        r_strb;
    logic        r_clear;

    // Next-state values
    logic [1:0]  w_state_nxt;
    logic        w_phase_nxt;
    logic [6:0]  w_index_nxt;
    logic [6:0]  w_nbits_nxt;
    logic [82:0] w_scope_nxt;
    logic        w_busy_nxt;
    logic        w_done_nxt;
    logic        w_valid_nxt;
    logic [14:0] w_crc_nxt;
    logic        w_bitval_nxt;
    logic        w_strb_nxt;
    logic        w_clear_nxt;

    logic        w_accept;
    logic [3:0]  w_dlc_clamped;
    logic [6:0]  w_nbits;

    assign w_accept      = (r_state == S_IDLE) && start;
    // DLC bits go out unclamped; only the data byte count is clamped.
    assign w_dlc_clamped = (dlc_in > c_MAX_DLC) ? c_MAX_DLC : dlc_in;
    assign w_nbits       = 7'd19 + (rtr_in ? 7'd0 : {w_dlc_clamped, 3'b000});

    // Outputs are registered from the next-state decode, so every output
    // reflects the state the machine is in during that cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_phase_nxt  = r_phase;
        w_index_nxt  = r_index;
        w_nbits_nxt  = r_nbits;
        w_scope_nxt  = r_scope;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_valid_nxt  = r_valid;
        w_crc_nxt    = r_crc;
        w_bitval_nxt = r_bitval;
        w_strb_nxt   = 1'b0;
        w_clear_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_CLEAR;
                    // SOF, ID, RTR, IDE, r0, DLC, data; excess data bits are
                    // simply never reached because the count stops first.
                    w_scope_nxt = {1'b0, id_in, rtr_in, 2'b00, dlc_in, data_in};
                    w_nbits_nxt = w_nbits;
                    w_valid_nxt = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_clear_nxt = 1'b1;
                end
            end
            S_CLEAR: begin
                w_state_nxt  = S_SHIFT;
                w_phase_nxt  = 1'b0;
                w_index_nxt  = 7'd0;
                w_bitval_nxt = r_scope[82];
            end
            S_SHIFT: begin
                if (!r_phase) begin
                    w_phase_nxt = 1'b1;
                    w_strb_nxt  = 1'b1;
                end else if (r_index == r_nbits - 7'd1) begin
                    w_state_nxt  = S_CAPTURE;
                    w_phase_nxt  = 1'b0;
                    w_bitval_nxt = 1'b0;
                end else begin
                    w_phase_nxt  = 1'b0;
                    w_index_nxt  = r_index + 7'd1;
                    w_scope_nxt  = {r_scope[81:0], 1'b0};
                    w_bitval_nxt = r_scope[81];
                end
            end
            S_CAPTURE: begin
                // crc_in already includes the final strobe at this point.
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
                w_valid_nxt = 1'b1;
                w_crc_nxt   = crc_in;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_phase  <= 1'b0;
            r_index  <= 7'd0;
            r_nbits  <= 7'd0;
            r_scope  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_valid  <= 1'b0;
            r_crc    <= 15'd0;
            r_bitval <= 1'b0;
            r_strb   <= 1'b0;
            r_clear  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_phase  <= w_phase_nxt;
            r_index  <= w_index_nxt;
            r_nbits  <= w_nbits_nxt;
            r_scope  <= w_scope_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_valid  <= w_valid_nxt;
            r_crc    <= w_crc_nxt;
            r_bitval <= w_bitval_nxt;
            r_strb   <= w_strb_nxt;
            r_clear  <= w_clear_nxt;
        end
    end

`ifdef CAN_CRC_SELFCHECK_EN
    // Shadow LFSR tracks exactly what the CRC_Unit sees on its interface.
    logic [14:0] r_lfsr;
    logic [14:0] w_lfsr_shift;
    logic        w_lfsr_fb;
    logic        r_mismatch;

    assign w_lfsr_fb    = r_bitval ^ r_lfsr[14];
    assign w_lfsr_shift = {r_lfsr[13:0], 1'b0} ^ (w_lfsr_fb ? 15'h4599 : 15'h0000);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_lfsr     <= 15'd0;
            r_mismatch <= 1'b0;
        end else begin
            if (r_clear) begin
                r_lfsr <= 15'd0;
            end else if (r_strb) begin
                r_lfsr <= w_lfsr_shift;
            end

            if (w_accept) begin
                r_mismatch <= 1'b0;
            end else if (r_state == S_CAPTURE) begin
                r_mismatch <= (r_lfsr != crc_in);
            end
        end
    end

    assign crc_mismatch = r_mismatch;
`else
    assign crc_mismatch = 1'b0;
`endif

    assign busy        = r_busy;
    assign done        = r_done;
    assign crc_valid   = r_valid;
    assign crc_out     = r_crc;
    assign crc_bitval  = r_bitval;
    assign crc_bitstrb = r_strb;
    assign crc_clear   = r_clear;

endmodule
`default_nettype wire

// File: tb/tb_can_crc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_can_crc_sequencer
// Purpose  : Self-checking bench for can_crc_sequencer. Models the CRC_Unit,
//            predicts each frame's scope bits, CRC and latency into a
//            scoreboard, and compares them when done is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_can_crc_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [10:0] id_in;
    logic        rtr_in;
    logic [3:0]  dlc_in;
    logic [63:0] data_in;
    logic        busy;
    logic        done;
    logic        crc_valid;
    logic [14:0] crc_out;
    logic        crc_bitval;
    logic        crc_bitstrb;
    logic        crc_clear;
    logic [14:0] crc_in;
    logic        crc_mismatch;

    logic [14:0] m_crc;
    logic [14:0] force_mask = 15'd0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [14:0] crc;
        int          lat;
        int          n;
        logic [82:0] bits;
        logic        mm;
    } exp_t;

    exp_t sb[$];

    always #5 clock = ~clock;

    can_crc_sequencer dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .id_in        (id_in),
        .rtr_in       (rtr_in),
        .dlc_in       (dlc_in),
        .data_in      (data_in),
        .busy         (busy),
        .done         (done),
        .crc_valid    (crc_valid),
        .crc_out      (crc_out),
        .crc_bitval   (crc_bitval),
        .crc_bitstrb  (crc_bitstrb),
        .crc_clear    (crc_clear),
        .crc_in       (crc_in),
        .crc_mismatch (crc_mismatch)
    );

    function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
        logic [14:0] n;
        n = {c[13:0], 1'b0};
        if (b ^ c[14]) n = n ^ 15'h4599;
        return n;
    endfunction

    // CRC_Unit model
    always @(posedge clock) begin
        if (!reset_n || crc_clear) m_crc <= 15'd0;
        else if (crc_bitstrb)      m_crc <= crc_step(m_crc, crc_bitval);
    end
    assign crc_in = m_crc ^ force_mask;

    function automatic exp_t make_exp(input logic [10:0] id, input logic rtr,
                                      input logic [3:0] dlc, input logic [63:0] data);
        exp_t e;
        logic q[$];
        int   dl;
        int   nd;
        logic [14:0] c;
        c = 15'd0;
        e.bits = '0;
        e.mm = 1'b0;
        q.push_back(1'b0);
        for (int i = 10; i >= 0; i--) q.push_back(id[i]);
        q.push_back(rtr);
        q.push_back(1'b0);
        q.push_back(1'b0);
        for (int i = 3; i >= 0; i--) q.push_back(dlc[i]);
        dl = int'(dlc);
        nd = rtr ? 0 : 8 * ((dl > 8) ? 8 : dl);
        for (int i = 0; i < nd; i++) q.push_back(data[63 - i]);
        foreach (q[k]) begin
            c = crc_step(c, q[k]);
            e.bits = {e.bits[81:0], q[k]};
        end
        e.n = q.size();
        e.lat = 2 * e.n + 2;
        e.crc = c;
        return e;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [82:0] obs, input logic [82:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                             input logic [63:0] data, input int dup_at, input bit do_force,
                             output int lat, output logic [82:0] bits);
        exp_t e;
        int t;
        int strobes;
        int clears;
        int force_at;
        bit got;
        bit busy_ok;
        logic [82:0] obsv;

        e = make_exp(id, rtr, dlc, data);
        force_at = e.lat - 1;
        if (do_force) begin
            e.crc = e.crc ^ 15'h0001;
            e.mm  = 1'b1;
        end
        sb.push_back(e);

        id_in = id; rtr_in = rtr; dlc_in = dlc; data_in = data;
        start = 1'b1;
        tick();
        start = 1'b0;
        t = 0; strobes = 0; clears = 0; got = 0; busy_ok = 1; obsv = '0;
        if (crc_clear) clears++;
        check("busy_after_start", busy, 1'b1);
        check("valid_cleared", crc_valid, 1'b0);
        check("mismatch_cleared", crc_mismatch, 1'b0);

        while (!got && t < 400) begin
            start = (t == dup_at);
            if (t == dup_at) id_in = ~id;
            tick();
            t++;
            start = 1'b0;
            force_mask = (do_force && t == force_at) ? 15'h0001 : 15'h0000;
            if (crc_bitstrb) begin
                strobes++;
                obsv = {obsv[81:0], crc_bitval};
            end
            if (crc_clear) clears++;
            if (done) got = 1;
            else if (!busy) busy_ok = 0;
        end
        force_mask = 15'd0;
        check("done_seen", got, 1'b1);

        e = sb.pop_front();
        check("latency", t, e.lat);
        check("crc_out", crc_out, e.crc);
        check("crc_valid", crc_valid, 1'b1);
        check("strobe_count", strobes, e.n);
        check("scope_bits", obsv, e.bits);
        check("mismatch", crc_mismatch, e.mm);
        check("busy_held", busy_ok, 1'b1);

        repeat (3) begin
            tick();
            if (crc_clear) clears++;
        end
        check("clear_once", clears, 1);
        check("idle_after", {busy, done, crc_valid}, 3'b001);
        check("mismatch_held", crc_mismatch, e.mm);
        lat = t;
        bits = obsv;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        int t;
        logic [82:0] bits;
        logic [82:0] lit;

        reset_n = 1'b0; start = 1'b1;
        id_in = '0; rtr_in = 1'b0; dlc_in = '0; data_in = '0;
        repeat (3) tick();
        check("reset_outputs",
              {busy, done, crc_valid, crc_out, crc_bitval, crc_bitstrb, crc_clear, crc_mismatch}, '0);
        start = 1'b0;
        reset_n = 1'b1;
        tick();

        // Data frame, 4 bytes
        run_frame(11'h123, 1'b0, 4'd4, 64'hDEADBEEF_00000000, -1, 1'b0, lat, bits);
        check("tp1_latency", lat, 104);
        lit = {32'd0, 1'b0, 11'h123, 1'b0, 6'b000100, 32'hDEADBEEF};
        check("tp1_bits_literal", bits, lit);

        // Remote frame: DLC shifted but no data bits
        run_frame(11'h4A5, 1'b1, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, -1, 1'b0, lat, bits);
        check("rtr_latency", lat, 40);

        // DLC above the maximum: data clamped to 8 bytes
        run_frame(11'h00F, 1'b0, 4'd15, 64'h0123456789ABCDEF, -1, 1'b0, lat, bits);
        check("dlc15_latency", lat, 168);
        check("dlc15_dlc_bits", bits[67:64], 4'b1111);

        // Start re-pulsed while busy is ignored
        run_frame(11'h7FF, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 10, 1'b0, lat, bits);

        // Reset in the middle of the sequence
        id_in = 11'h555; rtr_in = 1'b0; dlc_in = 4'd8; data_in = 64'hCAFEF00D_12345678;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0; t = 0;
        while (n < 20 && t < 200) begin
            tick();
            t++;
            if (crc_bitstrb) n++;
        end
        check("reached_bit20", n, 20);
        reset_n = 1'b0;
        tick();
        check("abort_outputs",
              {busy, done, crc_valid, crc_out, crc_bitval, crc_bitstrb, crc_clear, crc_mismatch}, '0);
        reset_n = 1'b1;
        tick();
        run_frame(11'h555, 1'b0, 4'd8, 64'hCAFEF00D_12345678, -1, 1'b0, lat, bits);

`ifdef CAN_CRC_SELFCHECK_EN
        // Corrupted CRC_Unit result during capture
        run_frame(11'h0AA, 1'b0, 4'd1, 64'h3C00_0000_0000_0000, -1, 1'b1, lat, bits);
        run_frame(11'h0AA, 1'b0, 4'd1, 64'h3C00_0000_0000_0000, -1, 1'b0, lat, bits);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/can_crc_sequencer.md
Name: can_crc_sequencer

Overview:
- Controller for the CAN MAC CRC_Unit (ports BITVAL, BITSTRB, CLEAR, CRC).
- Latches a standard-format frame descriptor on a start handshake, clears the CRC unit, then serializes the CRC scope bit by bit. The scope is SOF, arbitration, control and data.
- Captures the resulting 15-bit CRC for the transmit and receive framers.
- Sits between the MAC frame builder and the single shared CRC_Unit instance.

Parameters:
- MAX_DLC, 8, maximum data bytes; a DLC above MAX_DLC is clamped to MAX_DLC.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  synchronous reset, active low
- start  in  1  request to compute the CRC of the presented frame
- id_in  in  11  standard identifier
- rtr_in  in  1  remote transmission request
- dlc_in  in  4  data length code
- data_in  in  64  payload; byte 0 in [63:56], MSB first
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse when crc_out is valid
- crc_valid  out  1  crc_out holds a valid result
- crc_out  out  15  captured CRC
- crc_bitval  out  1  to CRC_Unit BITVAL
- crc_bitstrb  out  1  to CRC_Unit BITSTRB
- crc_clear  out  1  to CRC_Unit CLEAR
- crc_in  in  15  from CRC_Unit CRC
- crc_mismatch  out  1  self-check failure flag (see Optional Feature)

Behaviour:
- Single clock domain. Reset is synchronous and active low: all state is updated only on the rising edge of clock, and reset_n=0 sampled at that edge resets the block.
- Reset values: busy=0, done=0, crc_valid=0, crc_out=0, crc_bitval=0, crc_bitstrb=0, crc_clear=0, crc_mismatch=0; state=IDLE.
- Reset mid-sequence aborts immediately. No partial result is kept.
- All outputs are registered.

State machine: IDLE -> CLEAR -> SHIFT -> CAPTURE -> IDLE.
- IDLE:
  - start=1 latches id_in, rtr_in, dlc_in and data_in.
  - Clears crc_valid and goes to CLEAR.
- CLEAR:
  - crc_clear=1 for exactly one cycle.
  - Bit index reset to 0 and phase reset to 0.
  - Goes to SHIFT.
- SHIFT:
  - Two cycles per bit.
  - Phase 0: crc_bitval = scope bit[index], crc_bitstrb=0.
  - Phase 1: crc_bitval held, crc_bitstrb=1.
  - After phase 1 of the last bit, goes to CAPTURE; otherwise index+1 and back to phase 0.
- CAPTURE:
  - crc_bitstrb=0, crc_bitval=0.
  - crc_out <= crc_in, crc_valid=1, done=1 for this cycle.
  - Goes to IDLE.

Handshake and timing:
- busy=1 from the cycle after start is accepted through the CAPTURE cycle inclusive.
- start is ignored while busy.
- start asserted in the same cycle that CAPTURE completes is not accepted; it is accepted next cycle in IDLE.
- crc_valid stays 1 until the next accepted start or reset.

Scope bit order, first bit to last:
- SOF=0
- id[10..0]
- RTR
- IDE=0
- r0=0
- DLC[3..0] as received (unclamped)
- data bits: data_in[63] downward

Bit count N:
- N = 19 + (rtr ? 0 : 8*min(dlc, MAX_DLC)).
- Range 19..83; the index counter is 7 bits.
- Start-to-done latency: done is asserted 2N+2 cycles after the start-sampling edge.
- DLC 9..15 shifts its true DLC bits but sends only MAX_DLC data bytes.
- RTR=1 with DLC>0: no data bits are shifted.

Optional Feature:
- Macro: CAN_CRC_SELFCHECK_EN.
- Defined:
  - The block runs an internal CRC-15 LFSR (polynomial 0x4599, init 0) fed the same bit on each strobe phase-1 cycle.
  - In CAPTURE, crc_mismatch <= (internal != crc_in).
  - crc_mismatch is held until the next accepted start or reset.
- Undefined:
  - No LFSR is built.
  - crc_mismatch is tied to 0.

Test Plan:
- Reset, then start with id=0x123, rtr=0, dlc=4, data=64'hDEADBEEF_00000000 -> N=51 bits, identical in order to {0,0x123,0,6'b000100,0xDEADBEEF}; done at cycle 104 after start; crc_out equals the golden CRC-15 model; crc_valid=1; crc_mismatch=0.
- rtr=1, dlc=8 -> 19 strobes only; done at cycle 40; no data bits on crc_bitval.
- dlc=15, rtr=0 -> DLC bits shifted as 1111; 64 data bits shifted; N=83; done at cycle 168.
- start pulsed while busy, at cycle 10 -> ignored; one done only; crc_clear pulsed exactly once.
- reset_n=0 at bit index 20 -> next cycle all outputs 0; a new start then gives a correct CRC.
- With CAN_CRC_SELFCHECK_EN, force one crc_in bit during CAPTURE -> crc_mismatch=1, held until the next start.
